id_exe_reg: RTL

ID_EXE_REG -- requirements
Module: id_exe_reg

---
 rtl/id_exe_reg.sv | 114 +++++++++++
 1 files changed

// File: rtl/id_exe_reg.sv
// id_exe_reg: ID/EXE pipeline register with freeze/flush control and saturating stall/flush counters
module id_exe_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        flush,
   input  logic        WB_EN_in,
   input  logic        MEM_R_EN_in,
   input  logic        MEM_W_EN_in,
   input  logic        B_in,
   input  logic        S_in,
   input  logic        imm_in,
   input  logic [3:0]  EXE_CMD_in,
   input  logic [31:0] PC_in,
   input  logic [31:0] Val_Rn_in,
   input  logic [31:0] Val_Rm_in,
   input  logic [11:0] Shift_operand_in,
   input  logic [23:0] Signed_imm_24_in,
   input  logic [3:0]  Dest_in,
   input  logic [3:0]  src1_in,
   input  logic [3:0]  src2_in,
   input  logic [3:0]  SR_in,
   output logic        WB_EN_out,
   output logic        MEM_R_EN_out,
   output logic        MEM_W_EN_out,
   output logic        B_out,
   output logic        S_out,
   output logic        imm_out,
   output logic [3:0]  EXE_CMD_out,
   output logic [31:0] PC_out,
   output logic [31:0] Val_Rn_out,
   output logic [31:0] Val_Rm_out,
   output logic [11:0] Shift_operand_out,
   output logic [23:0] Signed_imm_24_out,
   output logic [3:0]  Dest_out,
   output logic [3:0]  src1_out,
   output logic [3:0]  src2_out,
   output logic [3:0]  SR_out,
   output logic        valid_out,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);
   typedef struct packed {
      logic        wb_en;
      logic        mem_r_en;
      logic        mem_w_en;
      logic        b;
      logic        s;
      logic        imm;
      logic [3:0]  exe_cmd;
      logic [31:0] pc;
      logic [31:0] val_rn;
      logic [31:0] val_rm;
      logic [11:0] shift_operand;
      logic [23:0] signed_imm_24;
      logic [3:0]  dest;
      logic [3:0]  src1;
      logic [3:0]  src2;
      logic [3:0]  sr;
      logic        valid;
   } stage_t;

   stage_t stage_q;
   stage_t stage_in;

   // Bundle the decode-stage fields into one record; a loaded stage is always valid
   always_comb begin
      stage_in = '{wb_en: WB_EN_in, mem_r_en: MEM_R_EN_in, mem_w_en: MEM_W_EN_in, b: B_in, s: S_in,
                   imm: imm_in, exe_cmd: EXE_CMD_in, pc: PC_in, val_rn: Val_Rn_in, val_rm: Val_Rm_in,
                   shift_operand: Shift_operand_in, signed_imm_24: Signed_imm_24_in, dest: Dest_in,
                   src1: src1_in, src2: src2_in, sr: SR_in, valid: 1'b1};
   end

   // Flush inserts an all-zero bubble, freeze holds, otherwise load; reset is a bubble too
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stage_q <= '0;
      else if (flush)
         stage_q <= '0;
      else if (!freeze)
         stage_q <= stage_in;
   end

   // Saturating counters: stalls only count when a real instruction is held and no flush wins
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (freeze && !flush && stage_q.valid && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
         if (flush && flush_cnt != 16'hFFFF)
            flush_cnt <= flush_cnt + 16'd1;
      end
   end

   assign WB_EN_out         = stage_q.wb_en;
   assign MEM_R_EN_out      = stage_q.mem_r_en;
   assign MEM_W_EN_out      = stage_q.mem_w_en;
   assign B_out             = stage_q.b;
   assign S_out             = stage_q.s;
   assign imm_out           = stage_q.imm;
   assign EXE_CMD_out       = stage_q.exe_cmd;
   assign PC_out            = stage_q.pc;
   assign Val_Rn_out        = stage_q.val_rn;
   assign Val_Rm_out        = stage_q.val_rm;
   assign Shift_operand_out = stage_q.shift_operand;
   assign Signed_imm_24_out = stage_q.signed_imm_24;
   assign Dest_out          = stage_q.dest;
   assign src1_out          = stage_q.src1;
   assign src2_out          = stage_q.src2;
   assign SR_out            = stage_q.sr;
   assign valid_out         = stage_q.valid;
endmodule
